// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the memory-wait timeout limit.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == WAIT_LIMIT) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller.
// stallCount exists only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_controller_if;
  logic [4:0]  idLHSRegisterIndex;
  logic [4:0]  idRHSRegisterIndex;
  logic [4:0]  exWriteRegisterIndex;
  logic        exMemRead;
  logic        exRedirect;
  logic        memBusy;
  logic        pcHold;
  logic        ifIdHold;
  logic        idExHold;
  logic        exMemHold;
  logic        ifIdFlush;
  logic        idExFlush;
  logic        memTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCount;
`endif

  modport master (
    output idLHSRegisterIndex, idRHSRegisterIndex, exWriteRegisterIndex,
    output exMemRead, exRedirect, memBusy,
    input  pcHold, ifIdHold, idExHold, exMemHold, ifIdFlush, idExFlush, memTimeout
`ifdef HAZARD_PERF_CNT_EN
    , input stallCount
`endif
  );

  modport slave (
    input  idLHSRegisterIndex, idRHSRegisterIndex, exWriteRegisterIndex,
    input  exMemRead, exRedirect, memBusy,
    output pcHold, ifIdHold, idExHold, exMemHold, ifIdFlush, idExFlush, memTimeout
`ifdef HAZARD_PERF_CNT_EN
    , output stallCount
`endif
  );
endinterface

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Flags an ID instruction that reads the destination of a load still in EX.
// Writes to x0 never create a dependency.
module load_use_detector (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing for the in-order pipeline: load-use, redirects and
// data-memory waits. Stall counter built only with HAZARD_PERF_CNT_EN.
//
// state    | meaning
// RUN      | normal flow; resolves load-use and redirects
// MEM_WAIT | data memory busy; pipeline frozen, redirects queued
// REDIRECT | one-cycle flush of a redirect queued during a wait
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
(
  input logic                         clk,
  input logic                         rst,
  pipeline_hazard_controller_if.slave hz
);

  hazard_state_t state, state_next;
  logic          pending, pending_next;
  logic [7:0]    wait_cnt;
  logic          mem_timeout;
  logic          load_use;
  logic          pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic          if_id_flush, id_ex_flush;

  load_use_detector u_load_use_detector (
    .ex_mem_read (hz.exMemRead),
    .ex_rd       (hz.exWriteRegisterIndex),
    .id_rs1      (hz.idLHSRegisterIndex),
    .id_rs2      (hz.idRHSRegisterIndex),
    .load_use    (load_use)
  );

  always_comb begin
    state_next   = state;
    pending_next = pending;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    unique case (state)
      RUN: begin
        if (hz.memBusy) begin
          {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
          pending_next = hz.exRedirect;
          state_next   = MEM_WAIT;
        end else if (hz.exRedirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.exRedirect) pending_next = 1'b1;
        if (hz.memBusy) begin
          {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
        end else begin
          state_next = pending_next ? REDIRECT : RUN;
        end
      end
      REDIRECT: begin
        if (hz.memBusy) begin
          {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b1111;
          state_next = MEM_WAIT;
        end else begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          pending_next = 1'b0;
          state_next   = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Reset flushes both barriers so the pipeline restarts on NOPs.
    if (rst) begin
      {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} = 4'b0000;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      pending_next = 1'b0;
      state_next   = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pending     <= 1'b0;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (state != MEM_WAIT && state_next == MEM_WAIT) begin
        wait_cnt <= 8'd0;
      end else if (state == MEM_WAIT) begin
        wait_cnt <= sat_inc(wait_cnt);
      end
      // Set on the same edge that brings wait_cnt to the limit.
      if (state == MEM_WAIT && wait_cnt >= WAIT_LIMIT - 8'd1) mem_timeout <= 1'b1;
    end
  end

  assign hz.pcHold     = pc_hold;
  assign hz.ifIdHold   = if_id_hold & ~if_id_flush;
  assign hz.idExHold   = id_ex_hold & ~id_ex_flush;
  assign hz.exMemHold  = ex_mem_hold;
  assign hz.ifIdFlush  = if_id_flush;
  assign hz.idExFlush  = id_ex_flush;
  assign hz.memTimeout = mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)          stall_cnt <= 32'd0;
    else if (pc_hold) stall_cnt <= stall_cnt + 32'd1;
  end

  assign hz.stallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized traffic against a behavioural model of the stall/flush rules.
module tb_pipeline_hazard_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: memory busy freezes everything; a redirect seen while frozen is
  // replayed as a flush one cycle after the release cycle.
  bit          m_wait;
  bit          m_pend;
  bit          m_due;
  bit          m_to;
  int          m_cyc;
  logic [31:0] m_stalls;
  logic [5:0]  exp_ctl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {hz.pcHold, hz.ifIdHold, hz.idExHold, hz.exMemHold, hz.ifIdFlush, hz.idExFlush};
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic apply(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit mr, input bit redir, input bit busy);
    bit lu;
    @(negedge clk);
    rst                     = r;
    hz.idLHSRegisterIndex   = rs1;
    hz.idRHSRegisterIndex   = rs2;
    hz.exWriteRegisterIndex = rd;
    hz.exMemRead            = mr;
    hz.exRedirect           = redir;
    hz.memBusy              = busy;
    #1;
    lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    if (r)           exp_ctl = 6'b000011;
    else if (busy)   exp_ctl = 6'b111100;
    else if (m_wait) exp_ctl = 6'b000000;
    else if (m_due)  exp_ctl = 6'b000011;
    else if (redir)  exp_ctl = 6'b000011;
    else if (lu)     exp_ctl = 6'b110001;
    else             exp_ctl = 6'b000000;
    chk("ctl", {26'd0, ctl()}, {26'd0, exp_ctl});
    chk("excl", {30'd0, hz.ifIdHold & hz.ifIdFlush, hz.idExHold & hz.idExFlush}, 32'd0);
    chk("timeout", {31'd0, hz.memTimeout}, {31'd0, m_to});
`ifdef HAZARD_PERF_CNT_EN
    chk("stalls", hz.stallCount, m_stalls);
`endif
    if (r) begin
      m_wait = 0; m_pend = 0; m_due = 0; m_to = 0; m_cyc = 0; m_stalls = '0;
    end else begin
      if (m_wait) begin
        if (m_cyc < 255) m_cyc++;
        if (m_cyc == 255) m_to = 1;
      end
      if (busy) begin
        if (!m_wait) m_cyc = 0;
        m_pend = m_pend | redir | m_due;
        m_wait = 1;
        m_due  = 0;
      end else if (m_wait) begin
        m_due  = m_pend | redir;
        m_pend = 0;
        m_wait = 0;
      end else begin
        m_due = 0;
      end
      if (exp_ctl[5]) m_stalls = m_stalls + 32'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
  endtask

  initial begin
    int   busy_left;
    bit   r, mr, redir, busy;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    hz.idLHSRegisterIndex = '0; hz.idRHSRegisterIndex = '0; hz.exWriteRegisterIndex = '0;
    hz.exMemRead = 0; hz.exRedirect = 0; hz.memBusy = 0;

    // Reset state
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 5'd5, 0, 5'd5, 1, 0, 1);
    chk("rst_ctl", {26'd0, ctl()}, 32'h03);
    chk("rst_timeout", {31'd0, hz.memTimeout}, 32'd0);

    // Load-use and x0
    apply(0, 5'd5, 5'd9, 5'd5, 1, 0, 0);
    chk("lu_ctl", {26'd0, ctl()}, 32'h31);
    idle(1);
    chk("lu_release", {26'd0, ctl()}, 32'h00);
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_stall_cnt", hz.stallCount, 32'd1);
`endif
    apply(0, 5'd0, 5'd9, 5'd0, 1, 0, 0);
    chk("x0_ctl", {26'd0, ctl()}, 32'h00);
    apply(0, 5'd7, 5'd5, 5'd5, 1, 0, 0);
    chk("lu_rs2_ctl", {26'd0, ctl()}, 32'h31);

    // Redirect together with load-use: flush wins
    apply(0, 5'd5, 5'd0, 5'd5, 1, 1, 0);
    chk("redir_lu_ctl", {26'd0, ctl()}, 32'h03);

    // Redirect during a three-cycle memory wait
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("rdw_c1", {26'd0, ctl()}, 32'h3c);
    apply(0, 0, 0, 0, 0, 1, 1);
    chk("rdw_c2", {26'd0, ctl()}, 32'h3c);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("rdw_c3", {26'd0, ctl()}, 32'h3c);
    idle(1);
    chk("rdw_release", {26'd0, ctl()}, 32'h00);
    idle(1);
    chk("rdw_flush", {26'd0, ctl()}, 32'h03);
    idle(1);
    chk("rdw_run", {26'd0, ctl()}, 32'h00);

    // Reset in the middle of a wait with a queued redirect
    apply(0, 0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0, 1);
    chk("rmw_rst_ctl", {26'd0, ctl()}, 32'h03);
    idle(1);
    chk("rmw_no_flush", {26'd0, ctl()}, 32'h00);
    chk("rmw_timeout", {31'd0, hz.memTimeout}, 32'd0);
    idle(1);
    chk("rmw_run", {26'd0, ctl()}, 32'h00);

    // Timeout: memory busy for 300 cycles
    for (int k = 0; k < 300; k++) begin
      apply(0, 0, 0, 0, 0, 0, 1);
      if (k == 255) chk("to_before", {31'd0, hz.memTimeout}, 32'd0);
      if (k == 256) chk("to_set", {31'd0, hz.memTimeout}, 32'd1);
    end
    idle(3);
    chk("to_sticky", {31'd0, hz.memTimeout}, 32'd1);
    apply(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("to_cleared", {31'd0, hz.memTimeout}, 32'd0);

    // Randomized traffic
    busy_left = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if (busy_left == 0 && $urandom_range(0, 9) == 0)
        busy_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 4);
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      mr    = ($urandom_range(0, 9) < 4);
      redir = ($urandom_range(0, 9) < 2);
      apply(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), mr, redir, busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 The block SHALL expose these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- idLHSRegisterIndex  in  5  rs1 of the instruction in ID
- idRHSRegisterIndex  in  5  rs2 of the instruction in ID
- exWriteRegisterIndex  in  5  rd of the instruction in EX
- exMemRead  in  1  EX instruction is a load
- exRedirect  in  1  EX resolved a taken branch or jump
- memBusy  in  1  data memory not ready this cycle
- pcHold  out  1  PC keeps its value
- ifIdHold  out  1  IF/ID barrier keeps its contents
- idExHold  out  1  drives the ID/EX barrier dontUpdate input
- exMemHold  out  1  EX/MEM barrier keeps its contents
- ifIdFlush  out  1  IF/ID barrier loads a NOP
- idExFlush  out  1  ID/EX barrier loads a bubble (control bits zero)
- memTimeout  out  1  sticky flag: memory wait exceeded limit
- stallCount  out  32  performance counter; present only with HAZARD_PERF_CNT_EN

Function
REQ-003 The FSM SHALL have exactly three states: RUN, MEM_WAIT and REDIRECT.
REQ-004 loadUse SHALL be defined as exMemRead && exWriteRegisterIndex!=0 && (exWriteRegisterIndex==idLHSRegisterIndex || exWriteRegisterIndex==idRHSRegisterIndex).
REQ-005 All hold and flush outputs SHALL be combinational (Mealy) from the current state and inputs, so they act in the same cycle.
REQ-006 In RUN, priority SHALL be memBusy > exRedirect > loadUse.
- memBusy: assert all four holds, no flushes; next state MEM_WAIT.
- exRedirect: assert ifIdFlush and idExFlush, no holds; stay in RUN.
- loadUse: assert pcHold, ifIdHold and idExFlush; stay in RUN.
REQ-007 In RUN with memBusy and exRedirect both high, the redirect SHALL be latched into pendingRedirect.
REQ-008 In MEM_WAIT, all four holds SHALL be asserted while memBusy=1.
REQ-009 In MEM_WAIT, exRedirect=1 SHALL set pendingRedirect.
REQ-010 In MEM_WAIT, loadUse SHALL be ignored.
REQ-011 In MEM_WAIT with memBusy=0, all holds SHALL be released; next state SHALL be REDIRECT if pendingRedirect=1, else RUN.
REQ-012 REDIRECT SHALL assert ifIdFlush and idExFlush for exactly one cycle, clear pendingRedirect, and go to RUN.
REQ-013 If memBusy=1 in REDIRECT, the block SHALL assert all holds, suppress the flushes, and return to MEM_WAIT with pendingRedirect kept at 1.
REQ-014 An 8-bit waitCnt SHALL increment on each MEM_WAIT cycle and clear on entry to MEM_WAIT.
- It SHALL saturate at 255.
- memTimeout SHALL be set when waitCnt reaches 255 and SHALL remain set until rst.
REQ-015 A hold and a flush on the same barrier SHALL never be asserted together; flush wins.

Reset
REQ-016 While rst=1, the block SHALL assert ifIdFlush=1 and idExFlush=1, and every hold=0.
REQ-017 On rst, the block SHALL set state=RUN and clear pendingRedirect, waitCnt, memTimeout and stallCount.
REQ-018 rst in MEM_WAIT or REDIRECT SHALL discard any pending redirect.

Configuration
REQ-019 With HAZARD_PERF_CNT_EN defined, stallCount SHALL increment (wrapping at 2^32) each cycle pcHold=1.
REQ-020 Without HAZARD_PERF_CNT_EN, the stallCount port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 The FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, REDIRECT=2'd2) and the WAIT_LIMIT=255 constant SHALL live in the shared pipeline package.
REQ-022 The loadUse comparator SHALL be the sub-module load_use_detector; all other logic SHALL be inline.

Verification
REQ-023 Load-use: exMemRead=1, exWriteRegisterIndex=5, idLHSRegisterIndex=5 -> pcHold=1, ifIdHold=1, idExFlush=1 for one cycle; stallCount +1.
REQ-024 x0 case: the same stimulus with index 0 -> no hold, no flush.
REQ-025 Redirect during wait: memBusy high 3 cycles with exRedirect pulsed in cycle 2 -> holds for 3 cycles, then one cycle of ifIdFlush=idExFlush=1, then RUN.
REQ-026 Simultaneous: exRedirect=1 and loadUse=1 in RUN -> flushes only, pcHold=0.
REQ-027 Timeout: memBusy held 300 cycles -> memTimeout=1 from the cycle waitCnt=255 onward, and it stays 1 after memBusy drops.
REQ-028 Reset mid-wait: rst pulsed in MEM_WAIT with pendingRedirect=1 -> next cycle RUN, no REDIRECT flush, memTimeout=0.
